multi_pattern_seq_detector: RTL and testbench
=============================================

// Module: multi_pattern_seq_detector
// PURPOSE
//   Serial bit-stream pattern detector with NUM_PAT run-time programmable pattern slots.
//   Each slot is up to MAX_LEN bits long. One slot is active at a time, chosen by sel.
//   Pulses seq_detected on each match and keeps a saturating match count.
//   Sits downstream of the serial receive path and replaces fixed 5-bit, 4-pattern detection.
// PARAMETERS
//   MAX_LEN  8   maximum pattern length in bits (>=2)
//   NUM_PAT  4   number of pattern slots (>=2)
//   COUNT_W  16  width of seq_count
//   SEL_W    $clog2(NUM_PAT)  derived localparam, slot index width
//   LEN_W    $clog2(MAX_LEN+1)  derived localparam, length field width
// PORTS
//   clk           in   1        rising-edge clock
//   reset         in   1        synchronous, active-low reset
//   in_valid      in   1        in_bit is accepted on this edge
//   in_bit        in   1        serial data bit; newest bit goes in as LSB of the window
//   sel           in   SEL_W    active pattern slot
//   cfg_we        in   1        write cfg_pat/cfg_len into slot cfg_idx
//   cfg_idx       in   SEL_W    slot to write
//   cfg_pat       in   MAX_LEN  pattern; bit 0 = most recent bit, low cfg_len bits used
//   cfg_len       in   LEN_W    pattern length, legal range 1..MAX_LEN
//   seq_detected  out  1        one-cycle match pulse
//   seq_count     out  COUNT_W  matches since last clear
//   count_sat     out  1        seq_count is at its maximum value
// BEHAVIOUR
// - Reset (reset==0 at posedge) clears these registers to 0:
//   history, fill, seq_count, seq_detected, count_sat, sel_q.
//   Every slot is reset to pat=0, len=MAX_LEN. Reset takes priority over every other input.
// - Accept (in_valid==1):
//   win = {hist[MAX_LEN-2:0], in_bit}; hist <= win; fill <= min(fill+1, MAX_LEN).
// - Match condition: in_valid, (fill+1) >= L, and win[L-1:0] == pat[L-1:0].
//   L and pat are the active slot's registered values.
// - seq_detected is registered. It is high for exactly the one cycle after the accepting edge,
//   and 0 on any cycle whose edge had no match. in_valid==0 changes no state except
//   seq_detected, which goes to 0.
// - On a match, seq_count increments on the same edge as seq_detected.
//   It saturates at 2^COUNT_W-1 and never wraps. count_sat == (seq_count == all ones).
// - Clear event: a clear happens when sel != sel_q, or when cfg_we writes the slot equal to sel.
//   On that edge: seq_count<=0, count_sat<=0, fill<=in_valid?1:0, and no match is reported.
//   The bit is still shifted into hist. sel_q<=sel every edge.
// - cfg writes: a write with cfg_len==0 or cfg_len>MAX_LEN is ignored entirely
//   (no slot change, no clear).
// - Simultaneous cfg_we and in_valid: matching uses pre-write slot contents. If the write
//   hits the active slot, the clear-event rule suppresses the match.
// - A reset asserted mid-stream discards partial history. The fill guard prevents false matches
//   on the zeroed history (e.g. pattern 0000 needs 4 received zeros).
// CONFIGURATION
//   NON_OVERLAP_EN defined:
//     on a match edge, fill<=0 (history bits are kept but do not count toward fill).
//     The next match needs L freshly accepted bits.
//   Not defined (default): overlapping detection; fill is unaffected by a match.
// TESTING
//   1 Slot0=10111,L=5,sel=0; feed 1,0,1,1,1 -> seq_detected pulses once after 5th bit;
//     seq_count=1, count_sat=0.
//   2 Slot1=1010,L=4,sel=1; feed 1,0,1,0,1,0 -> default: pulses after bits 4 and 6, count=2;
//     with NON_OVERLAP_EN: pulse after bit 4 only, count=1.
//   3 After reset, slot2=0000,L=4; feed 0,0,0 -> no pulse; 4th 0 -> pulse, count=1.
//   4 After 3 matches on sel=0, change sel to 1 with in_valid=1 -> seq_count=0 next cycle;
//     no pulse on that edge; new slot needs L fresh bits before its first match.
//   5 COUNT_W=4, slot0=1,L=1; feed 17 ones -> count stops at 15, count_sat=1 from the 15th match,
//     pulses continue.
//   6 Drive reset=0 for one cycle mid-stream -> all outputs 0 next cycle; slots back to pat=0,L=MAX_LEN;
//     cfg_len=0 write -> ignored, no clear.

Source files
------------

// File: rtl/multi_pattern_seq_detector.sv
// Serial pattern detector with NUM_PAT run-time programmable slots of up to MAX_LEN bits.
// Optional build macro NON_OVERLAP_EN: a match restarts the fill count (non-overlapping detection).
module multi_pattern_seq_detector #(
    parameter  int MAX_LEN = 8,
    parameter  int NUM_PAT = 4,
    parameter  int COUNT_W = 16,
    localparam int SEL_W   = $clog2(NUM_PAT),
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic [SEL_W-1:0]   sel,
    input  logic               cfg_we,
    input  logic [SEL_W-1:0]   cfg_idx,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    output logic               seq_detected,
    output logic [COUNT_W-1:0] seq_count,
    output logic               count_sat
);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               det_q, det_d;
    logic               sat_q, sat_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [MAX_LEN-1:0] pat_q [NUM_PAT];
    logic [MAX_LEN-1:0] pat_d [NUM_PAT];
    logic [LEN_W-1:0]   len_q [NUM_PAT];
    logic [LEN_W-1:0]   len_d [NUM_PAT];

    logic [MAX_LEN-1:0] win_s;
    logic [MAX_LEN-1:0] act_pat_s;
    logic [LEN_W-1:0]   act_len_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [LEN_W:0]     fill_inc_s;
    logic               sel_ok_s;
    logic               cfg_ok_s;
    logic               clear_s;
    logic               match_s;

    // Window, active-slot lookup, clear/match decisions and next-state values.
    always_comb begin
        win_s      = {hist_q[MAX_LEN-2:0], in_bit};
        fill_inc_s = {1'b0, fill_q} + (LEN_W+1)'(1);
        sel_ok_s   = ({1'b0, sel} < (SEL_W+1)'(NUM_PAT));
        cfg_ok_s   = cfg_we && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN))
                     && ({1'b0, cfg_idx} < (SEL_W+1)'(NUM_PAT));

        if (sel_ok_s) begin
            act_pat_s = pat_q[sel];
            act_len_s = len_q[sel];
        end else begin
            act_pat_s = '0;
            act_len_s = LEN_W'(MAX_LEN);
        end

        mask_s = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (LEN_W'(i) < act_len_s);
        end

        // Matching uses pre-write slot contents; a write to the active slot clears instead.
        clear_s = (sel != sel_q) || (cfg_ok_s && (cfg_idx == sel));
        match_s = in_valid && !clear_s && sel_ok_s
                  && (fill_inc_s >= {1'b0, act_len_s})
                  && (((win_s ^ act_pat_s) & mask_s) == '0);

        hist_d = hist_q;
        fill_d = fill_q;
        if (in_valid) begin
            hist_d = win_s;
            if (fill_inc_s > (LEN_W+1)'(MAX_LEN)) begin
                fill_d = LEN_W'(MAX_LEN);
            end else begin
                fill_d = fill_inc_s[LEN_W-1:0];
            end
        end else begin
            hist_d = hist_q;
        end

        count_d = count_q;
        if (clear_s) begin
            fill_d  = in_valid ? LEN_W'(1) : '0;
            count_d = '0;
        end else if (match_s) begin
`ifdef NON_OVERLAP_EN
            fill_d = '0;
`endif
            if (count_q != '1) begin
                count_d = count_q + COUNT_W'(1);
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end

        sat_d = !clear_s && (count_d == '1);
        det_d = match_s;
        sel_d = sel;

        pat_d = pat_q;
        len_d = len_q;
        if (cfg_ok_s) begin
            pat_d[cfg_idx] = cfg_pat;
            len_d[cfg_idx] = cfg_len;
        end else begin
            pat_d = pat_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            det_q   <= 1'b0;
            sat_q   <= 1'b0;
            sel_q   <= '0;
            pat_q   <= '{default: '0};
            len_q   <= '{default: LEN_W'(MAX_LEN)};
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            det_q   <= det_d;
            sat_q   <= sat_d;
            sel_q   <= sel_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
        end
    end

    assign seq_detected = det_q;
    assign seq_count    = count_q;
    assign count_sat    = sat_q;

endmodule

// File: tb/tb_multi_pattern_seq_detector.sv
// Directed self-checking bench for multi_pattern_seq_detector (MAX_LEN=8, NUM_PAT=4, COUNT_W=4).
module tb_multi_pattern_seq_detector;

    localparam int MAX_LEN = 8;
    localparam int NUM_PAT = 4;
    localparam int COUNT_W = 4;
    localparam int SEL_W   = 2;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_bit;
    logic [SEL_W-1:0]   sel;
    logic               cfg_we;
    logic [SEL_W-1:0]   cfg_idx;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               seq_detected;
    logic [COUNT_W-1:0] seq_count;
    logic               count_sat;

    int n_assert = 0;
    int n_fail   = 0;

    multi_pattern_seq_detector #(.MAX_LEN(MAX_LEN), .NUM_PAT(NUM_PAT), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .sel(sel),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .seq_detected(seq_detected), .seq_count(seq_count), .count_sat(count_sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input logic det, input int cnt, input logic sat);
        chk({tag, ".det"}, {31'd0, seq_detected}, {31'd0, det});
        chk({tag, ".cnt"}, {28'd0, seq_count}, cnt);
        chk({tag, ".sat"}, {31'd0, count_sat}, {31'd0, sat});
    endtask

    task automatic feed(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic cfg(input logic [SEL_W-1:0] idx, input logic [MAX_LEN-1:0] pat,
                       input logic [LEN_W-1:0] len);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_pat = pat;
        cfg_len = len;
        tick();
        cfg_we  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0; sel = 2'd0;
        cfg_we = 1'b0; cfg_idx = 2'd0; cfg_pat = 8'd0; cfg_len = 4'd0;
        tick(); tick();
        chk_out("reset", 1'b0, 0, 1'b0);
        reset = 1'b1;

        // 1: slot0 = 10111, L=5
        cfg(2'd0, 8'b0001_0111, 4'd5);
        feed(1'b1); chk_out("t1.b1", 1'b0, 0, 1'b0);
        feed(1'b0); chk_out("t1.b2", 1'b0, 0, 1'b0);
        feed(1'b1); chk_out("t1.b3", 1'b0, 0, 1'b0);
        feed(1'b1); chk_out("t1.b4", 1'b0, 0, 1'b0);
        feed(1'b1); chk_out("t1.b5", 1'b1, 1, 1'b0);
        feed(1'b0); chk_out("t1.b6", 1'b0, 1, 1'b0);

        // 2: slot1 = 1010, L=4, overlapping vs non-overlapping
        cfg(2'd1, 8'b0000_1010, 4'd4);
        sel = 2'd1; tick();
        chk_out("t2.sel", 1'b0, 0, 1'b0);
        feed(1'b1); chk_out("t2.b1", 1'b0, 0, 1'b0);
        feed(1'b0); chk_out("t2.b2", 1'b0, 0, 1'b0);
        feed(1'b1); chk_out("t2.b3", 1'b0, 0, 1'b0);
        feed(1'b0); chk_out("t2.b4", 1'b1, 1, 1'b0);
        feed(1'b1); chk_out("t2.b5", 1'b0, 1, 1'b0);
        feed(1'b0);
`ifdef NON_OVERLAP_EN
        chk_out("t2.b6", 1'b0, 1, 1'b0);
`else
        chk_out("t2.b6", 1'b1, 2, 1'b0);
`endif

        // 3: after reset, slot2 = 0000 needs four received zeros
        reset = 1'b0; tick(); reset = 1'b1;
        chk_out("t3.rst", 1'b0, 0, 1'b0);
        cfg(2'd2, 8'b0000_0000, 4'd4);
        sel = 2'd2; tick();
        feed(1'b0); chk_out("t3.b1", 1'b0, 0, 1'b0);
        feed(1'b0); chk_out("t3.b2", 1'b0, 0, 1'b0);
        feed(1'b0); chk_out("t3.b3", 1'b0, 0, 1'b0);
        feed(1'b0); chk_out("t3.b4", 1'b1, 1, 1'b0);

        // 4: three matches on slot0 (pat 1, L=1), then switch to slot1 = 1101 with a bit
        cfg(2'd0, 8'b0000_0001, 4'd1);
        sel = 2'd0; tick();
        chk_out("t4.sel0", 1'b0, 0, 1'b0);
        feed(1'b1); chk_out("t4.m1", 1'b1, 1, 1'b0);
        feed(1'b1); chk_out("t4.m2", 1'b1, 2, 1'b0);
        feed(1'b1); chk_out("t4.m3", 1'b1, 3, 1'b0);
        cfg(2'd1, 8'b0000_1101, 4'd4);
        chk_out("t4.cfg1", 1'b0, 3, 1'b0);
        sel = 2'd1;
        feed(1'b0); chk_out("t4.switch", 1'b0, 0, 1'b0);
        feed(1'b1); chk_out("t4.stale", 1'b0, 0, 1'b0);
        feed(1'b1); chk_out("t4.f2", 1'b0, 0, 1'b0);
        feed(1'b0); chk_out("t4.f3", 1'b0, 0, 1'b0);
        feed(1'b1); chk_out("t4.f4", 1'b1, 1, 1'b0);
        feed(1'b1); chk_out("t4.f5", 1'b0, 1, 1'b0);
        feed(1'b0); chk_out("t4.f6", 1'b0, 1, 1'b0);
        // window would match, but the write to the active slot clears instead
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_pat = 8'b0000_1101; cfg_len = 4'd4;
        feed(1'b1); cfg_we = 1'b0;
        chk_out("t4.cfgclr", 1'b0, 0, 1'b0);

        // 5: saturation with 17 ones on slot0
        sel = 2'd0; tick();
        chk_out("t5.sel0", 1'b0, 0, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            feed(1'b1);
            chk_out("t5.sat", 1'b1, (k < 15) ? k : 15, (k >= 15));
        end

        // 6: mid-stream reset, reset slot contents, ignored illegal writes
        reset = 1'b0; in_valid = 1'b1; in_bit = 1'b1; tick();
        reset = 1'b1; in_valid = 1'b0;
        chk_out("t6.rst", 1'b0, 0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            feed(1'b0);
            chk_out("t6.z", 1'b0, 0, 1'b0);
        end
        feed(1'b0); chk_out("t6.z8", 1'b1, 1, 1'b0);
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_pat = 8'b0000_0001; cfg_len = 4'd0;
        feed(1'b0);
`ifdef NON_OVERLAP_EN
        chk_out("t6.len0", 1'b0, 1, 1'b0);
`else
        chk_out("t6.len0", 1'b1, 2, 1'b0);
`endif
        cfg_len = 4'd9;
        feed(1'b0); cfg_we = 1'b0;
`ifdef NON_OVERLAP_EN
        chk_out("t6.len9", 1'b0, 1, 1'b0);
`else
        chk_out("t6.len9", 1'b1, 3, 1'b0);
`endif
        tick();
        chk("t6.idle", {31'd0, seq_detected}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
